// File: rtl/i2c_read_arbiter_pkg.sv
// Shared definitions for the i2c read arbiter: FSM state codes, MPU6050
// register map, default slave address and a width helper.
package i2c_read_arbiter_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // MPU6050 register addresses
  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] ACCEL_XOUT_L = 8'h3C;
  localparam logic [7:0] ACCEL_YOUT_H = 8'h3D;
  localparam logic [7:0] ACCEL_YOUT_L = 8'h3E;
  localparam logic [7:0] ACCEL_ZOUT_H = 8'h3F;
  localparam logic [7:0] ACCEL_ZOUT_L = 8'h40;
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;

  // Default 7-bit slave address
  localparam logic [6:0] SLAVE_ADDR   = 7'h68;

  // Bits needed to index/count n values, never less than 1
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_read_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // Scan from farthest to nearest so the nearest request at/after ptr wins
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j[IW-1:0]]) begin
        grant              = '0;
        grant[j[IW-1:0]]   = 1'b1;
        idx                = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/i2c_read_arbiter.sv
// Shares a single i2c_master read engine between NUM_REQ requesters.
// Round-robin grant, start/available handshake toward the master, byte
// routed back to the winner only, per-phase timeout reported as rsp_err.
module i2c_read_arbiter
  import i2c_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_reg,
  output logic [NUM_REQ-1:0]   req_grant,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 m_start,
  output logic [7:0]           m_data_in,
  input  logic [7:0]           m_data_out,
  input  logic                 m_data_out_available,
  input  logic                 m_available
);

  localparam int IW = bits_for(NUM_REQ);
  localparam int CW = bits_for(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [1:0]               state_q, state_d;
  logic [IW-1:0]            rr_q, rr_d;
  logic [IW-1:0]            win_q, win_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_REQ-1:0]       req_grant_q, req_grant_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [7:0]               rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     busy_q, busy_d;
  logic                     m_start_q, m_start_d;
  logic [7:0]               m_data_in_q, m_data_in_d;

  logic [NUM_REQ-1:0]       pick_oh;
  logic [IW-1:0]            pick_idx;
  logic                     pick_any;
  logic [NUM_REQ-1:0][7:0]  reg_arr;
  logic [NUM_REQ-1:0]       win_oh;
  logic                     timeout;

  assign reg_arr = req_reg;
  assign win_oh  = NUM_REQ'(1) << win_q;
  assign timeout = (cnt_q == CNT_LAST);

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state and next-output logic for the arbitration FSM
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    req_grant_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    busy_d      = busy_q;
    m_start_d   = m_start_q;
    m_data_in_d = m_data_in_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d       = pick_idx;
          req_grant_d = pick_oh;
          m_data_in_d = reg_arr[pick_idx];
          busy_d      = 1'b1;
          rr_d        = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Master has taken the request once it goes unavailable under start
        if (m_start_q && !m_available) begin
          m_start_d = 1'b0;
          state_d   = ST_WAIT;
        end else if (timeout) begin
          m_start_d   = 1'b0;
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
          rsp_valid_d = win_oh;
          state_d     = ST_RESP;
        end else begin
          m_start_d = m_available;
        end
      end
      ST_WAIT: begin
        if (m_data_out_available) begin
          rsp_data_d  = m_data_out;
          rsp_valid_d = win_oh;
          state_d     = ST_RESP;
        end else if (timeout) begin
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
          rsp_valid_d = win_oh;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Phase counter restarts on every state change and saturates
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;
  end

  // Control state: FSM, round-robin pointer, winner, phase counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs toward requesters and the master
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_grant_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_data_in_q <= '0;
    end else begin
      req_grant_q <= req_grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      m_start_q   <= m_start_d;
      m_data_in_q <= m_data_in_d;
    end
  end

  assign req_grant = req_grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign m_start   = m_start_q;
  assign m_data_in = m_data_in_q;

endmodule

// File: tb/tb_i2c_read_arbiter.sv
// Bench for i2c_read_arbiter: i2c_master stubbed by a BFM (available drops
// 2 cycles after start, byte 40 cycles later), scoreboard queues for grants
// and responses, directed steps in one initial block.
module tb_i2c_read_arbiter;

  localparam int NR = 2;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_reg;
  logic [1:0]  req_grant, rsp_valid;
  logic [7:0]  rsp_data, m_data_in;
  logic        rsp_err, busy, m_start;
  logic [7:0]  m_data_out = 8'h00;
  logic        m_dav = 1'b0;
  logic        bfm_avail = 1'b1;
  logic        blk = 1'b0;
  logic        bfm_mute = 1'b0;
  logic        m_available;

  assign m_available = bfm_avail & ~blk;

  always #5 clk = ~clk;

  i2c_read_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_reg              (req_reg),
    .req_grant            (req_grant),
    .rsp_valid            (rsp_valid),
    .rsp_data             (rsp_data),
    .rsp_err              (rsp_err),
    .busy                 (busy),
    .m_start              (m_start),
    .m_data_in            (m_data_in),
    .m_data_out           (m_data_out),
    .m_data_out_available (m_dav),
    .m_available          (m_available)
  );

  typedef struct { logic [1:0] g; logic [7:0] a; } gexp_t;
  typedef struct { logic [1:0] v; logic [7:0] d; logic e; } rexp_t;

  gexp_t      gq[$];
  rexp_t      rq[$];
  logic [7:0] bq[$];
  gexp_t      ge;
  rexp_t      re;
  int errors = 0;
  int checks = 0;
  int starts = 0;
  logic prev_start = 1'b0;
  int ph = 0;
  int bc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master BFM, driven on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      ph = 0; bc = 0; bfm_avail = 1'b1; m_dav = 1'b0; bq.delete();
    end else begin
      case (ph)
        0: if (m_start && m_available) begin ph = 1; bc = 0; end
        1: begin bc++; if (bc == 2) begin bfm_avail = 1'b0; ph = 2; bc = 0; end end
        2: begin
          bc++;
          if (bc == 40) begin
            if (!bfm_mute && bq.size() > 0) begin
              m_data_out = bq.pop_front();
              m_dav = 1'b1;
            end
            ph = 3;
          end
        end
        default: begin m_dav = 1'b0; bfm_avail = 1'b1; ph = 0; end
      endcase
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (m_start && !prev_start) starts++;
      if (req_grant != 2'b00) begin
        if (gq.size() == 0) chk("grant_unexpected", 32'(req_grant), 32'd0);
        else begin
          ge = gq.pop_front();
          chk("grant", 32'(req_grant), 32'(ge.g));
          chk("m_data_in", 32'(m_data_in), 32'(ge.a));
          chk("busy_at_grant", 32'(busy), 32'd1);
          chk("grant_rsp_overlap", 32'(rsp_valid), 32'd0);
        end
      end
      if (rsp_valid != 2'b00) begin
        if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          re = rq.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(re.v));
          chk("rsp_data", 32'(rsp_data), 32'(re.d));
          chk("rsp_err", 32'(rsp_err), 32'(re.e));
        end
      end
    end
    prev_start = m_start;
  end

  task automatic wait_rsp(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == 2'b00 && n < 400);
    chk(tag, 32'(rsp_valid != 2'b00), 32'd1);
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_grant == 2'b00 && n < 400);
    chk(tag, 32'(req_grant != 2'b00), 32'd1);
  endtask

  task automatic wait_start(input logic lvl, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (m_start !== lvl && n < 400);
    chk(tag, 32'(m_start), 32'(lvl));
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_req_grant"}, 32'(req_grant), 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({pfx, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({pfx, "_busy"},      32'(busy),      32'd0);
    chk({pfx, "_m_start"},   32'(m_start),   32'd0);
    chk({pfx, "_m_data_in"}, 32'(m_data_in), 32'd0);
  endtask

  initial begin
    int n;
    int hi;
    reset = 1'b1; req_valid = 2'b00; req_reg = 16'h0000;
    #2 reset = 1'b0;
    #1 chk_outputs_zero("rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: single request from requester 0
    gq.push_back('{2'b01, 8'h3B});
    rq.push_back('{2'b01, 8'hA5, 1'b0});
    bq.push_back(8'hA5);
    req_reg = 16'h3D3B; req_valid = 2'b01;
    wait_rsp("t1_rsp_seen");
    req_valid = 2'b00;
    chk("t1_busy_in_resp", 32'(busy), 32'd1);
    chk("t1_start_count", 32'(starts), 32'd1);
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // 6: requester 1 drops req_valid right after its grant
    gq.push_back('{2'b10, 8'h3D});
    rq.push_back('{2'b10, 8'hC4, 1'b0});
    bq.push_back(8'hC4);
    req_valid = 2'b10;
    wait_grant("t6_grant_seen");
    req_valid = 2'b00;
    wait_rsp("t6_rsp_seen");
    repeat (3) @(negedge clk);

    // 2: both requesting, grants alternate
    gq.push_back('{2'b01, 8'h3B}); rq.push_back('{2'b01, 8'h11, 1'b0}); bq.push_back(8'h11);
    gq.push_back('{2'b10, 8'h3D}); rq.push_back('{2'b10, 8'h22, 1'b0}); bq.push_back(8'h22);
    gq.push_back('{2'b01, 8'h3B}); rq.push_back('{2'b01, 8'h33, 1'b0}); bq.push_back(8'h33);
    gq.push_back('{2'b10, 8'h3D}); rq.push_back('{2'b10, 8'h44, 1'b0}); bq.push_back(8'h44);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) wait_rsp("t2_rsp_seen");
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // 3: no data from the bus -> timeout exactly TO cycles after WAIT entry
    bfm_mute = 1'b1;
    gq.push_back('{2'b01, 8'h3B});
    rq.push_back('{2'b01, 8'h00, 1'b1});
    req_valid = 2'b01;
    wait_start(1'b1, "t3_start_hi");
    wait_start(1'b0, "t3_wait_entry");
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == 2'b00 && n < 200);
    chk("t3_timeout_latency", 32'(n), 32'(TO));
    req_valid = 2'b00;
    bfm_mute = 1'b0;
    repeat (2) @(negedge clk);
    gq.push_back('{2'b01, 8'h3B});
    rq.push_back('{2'b01, 8'h5A, 1'b0});
    bq.push_back(8'h5A);
    req_valid = 2'b01;
    wait_rsp("t3_next_rsp_seen");
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    // 4: master unavailable for 30 cycles
    blk = 1'b1;
    gq.push_back('{2'b01, 8'h3B});
    rq.push_back('{2'b01, 8'hC3, 1'b0});
    bq.push_back(8'hC3);
    req_valid = 2'b01;
    hi = 0;
    repeat (30) begin @(negedge clk); if (m_start) hi++; end
    chk("t4_start_while_unavail", 32'(hi), 32'd0);
    blk = 1'b0;
    wait_rsp("t4_rsp_seen");
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    // 5: reset in WAIT aborts silently, rr pointer back to 0 afterwards
    gq.push_back('{2'b01, 8'h3B});
    bq.push_back(8'h77);
    req_valid = 2'b01;
    wait_start(1'b1, "t5_start_hi");
    wait_start(1'b0, "t5_wait_entry");
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1 chk_outputs_zero("t5_async");
    repeat (3) @(negedge clk);
    gq.push_back('{2'b01, 8'h3B}); rq.push_back('{2'b01, 8'h81, 1'b0});
    gq.push_back('{2'b10, 8'h3D}); rq.push_back('{2'b10, 8'h82, 1'b0});
    req_valid = 2'b11;
    reset = 1'b1;
    bq.push_back(8'h81);
    bq.push_back(8'h82);
    wait_rsp("t5_rsp0_seen");
    req_valid = 2'b10;
    wait_rsp("t5_rsp1_seen");
    req_valid = 2'b00;
    repeat (5) @(negedge clk);

    chk("sb_grants_left", 32'(gq.size()), 32'd0);
    chk("sb_rsps_left",   32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
